addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor with status flags.
//  Splits a WIDTH-bit ripple-carry chain into STAGES registered segments; carry
//  is registered between segments. Valid/ready handshake on input and output.
//  Sits in the datapath as the ALU add/sub unit feeding the result/flag bus.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0, WIDTH >= 2
//  STAGES  4   pipeline segments = latency in cycles; 1..WIDTH
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/sub valid this cycle
//  in_ready   out  1      unit accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b, 1: a-b (a + ~b + 1)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//  overf      out  1      signed overflow = carry into MSB ^ carry out of MSB
//  zero       out  1      sum == 0
//  neg        out  1      sum[WIDTH-1]
// BEHAVIOUR
//  - Segment width SEG = WIDTH/STAGES. Stage k adds bits [k*SEG +: SEG] using
//    registered carry from stage k-1; stage 0 carry-in = sub.
//  - Operand bits of later segments skewed through delay registers; completed
//    low sum bits carried forward. Operand b XORed with sub at input.
//  - Latency exactly STAGES cycles from accepted input to out_valid, no stall.
//  - Global stall: advance = !out_valid | out_ready; in_ready = advance.
//    When advance=0 every stage register (data, carry, valid) holds.
//  - Input accepted iff in_valid & in_ready; accepted data never lost or duplicated.
//  - Output held stable while out_valid & !out_ready.
//  - Throughput one result/cycle when out_ready held high.
//  - Bubbles not collapsed; per-stage valid bit travels with data.
//  - Flags computed in final stage from full sum; registered with sum.
//  - Reset: all valid bits, sum, cout, overf, zero, neg = 0; in_ready = 1
//    in the cycle after reset. Reset mid-operation discards all in-flight ops.
//  - in_valid ignored while reset high.
//  - STAGES==1: single registered full-width ripple add.
// STRUCTURE
//  - Shared package: none required; SEG localparam computed in-module.
//  - Sub-module: addsub_seg (SEG-bit ripple adder: a, b, cin -> sum, cout,
//    carry into MSB), instantiated STAGES times via generate.
//  - Bit-level full adder cell inside addsub_seg via generate loop.
//  - Elaboration-time check: WIDTH % STAGES != 0 -> $error.
// TESTING (WIDTH=32, STAGES=4 unless noted)
//  1. a=0x7FFFFFFF, b=1, sub=0 -> after 4 cycles sum=0x80000000, overf=1, neg=1, cout=0.
//  2. a=5, b=5, sub=1 -> sum=0, zero=1, cout=1, overf=0; a=0, b=1, sub=1 -> sum=0xFFFFFFFF, cout=0.
//  3. a=0xFFFFFFFF, b=1, sub=0 -> sum=0, cout=1, zero=1, overf=0 (carry crosses all 4 segments).
//  4. back-to-back 8 ops with out_ready=1 -> 8 results on consecutive cycles in order;
//     then out_ready=0 for 3 cycles -> in_ready=0, outputs stable, no loss after release.
//  5. reset asserted with 3 ops in flight -> next cycle out_valid=0, flags/sum 0; no stale output later.
//  6. random 10k ops, WIDTH in {8,32,64}, STAGES in {1,2,WIDTH/4}, random in_valid/out_ready
//     -> scoreboard matches reference model for sum and all four flags.

Source files
------------

// File: rtl/addsub_pipe_pkg.sv
// Shared types and full-adder helpers for the pipelined adder/subtractor.
// Combinational only: no latency, no backpressure.
package addsub_pipe_pkg;

   typedef struct packed {
      logic cout;
      logic overf;
      logic zero;
      logic neg;
   } flags_t;

   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

endpackage

// File: rtl/addsub_seg.sv
// SEG-bit ripple-carry segment built from full-adder cells; purely combinational,
// no backpressure. cmsb is the carry into the segment's top bit (for overflow).
module addsub_seg
   import addsub_pipe_pkg::*;
#(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           cmsb
);

   logic [SEG:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < SEG; i++) begin : g_fa
      assign sum[i]   = fa_sum(a[i], b[i], c[i]);
      assign c[i+1]   = fa_carry(a[i], b[i], c[i]);
   end

   assign cout = c[SEG];
   assign cmsb = c[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: STAGES registered ripple segments, latency STAGES cycles.
// Global stall: every stage holds when the output is valid and not accepted.
module addsub_pipe
   import addsub_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overf,
   output logic             zero,
   output logic             neg
);

   localparam int SEG = WIDTH / STAGES;

   if ((WIDTH % STAGES) != 0 || WIDTH < 2 || STAGES < 1) begin : g_bad_params
      $error("addsub_pipe: WIDTH must be >= 2 and a multiple of STAGES");
   end

   logic   advance;
   flags_t flg;

   // Per-stage inputs: skewed operands, low sum bits already completed, carry, valid.
   logic [WIDTH-1:0] st_a [STAGES];
   logic [WIDTH-1:0] st_b [STAGES];
   logic [WIDTH-1:0] st_s [STAGES];
   logic             st_c [STAGES];
   logic             st_v [STAGES];

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign st_a[0] = a;
   assign st_b[0] = b ^ {WIDTH{sub}};
   assign st_s[0] = '0;
   assign st_c[0] = sub;
   assign st_v[0] = in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG-1:0]   seg_sum;
      logic             seg_cout;
      logic             seg_cmsb;
      logic [WIDTH-1:0] done;

      addsub_seg #(.SEG(SEG)) u_seg (
         .a    (st_a[k][k*SEG +: SEG]),
         .b    (st_b[k][k*SEG +: SEG]),
         .cin  (st_c[k]),
         .sum  (seg_sum),
         .cout (seg_cout),
         .cmsb (seg_cmsb)
      );

      always_comb begin
         done                 = st_s[k];
         done[k*SEG +: SEG]   = seg_sum;
      end

      if (k < STAGES - 1) begin : g_reg
         logic [WIDTH-1:0] ra, rb, rs;
         logic             rc, rv;

         always_ff @(posedge clock) begin
            if (reset) begin
               ra <= '0;
               rb <= '0;
               rs <= '0;
               rc <= 1'b0;
               rv <= 1'b0;
            end else if (advance) begin
               ra <= st_a[k];
               rb <= st_b[k];
               rs <= done;
               rc <= seg_cout;
               rv <= st_v[k];
            end
         end

         assign st_a[k+1] = ra;
         assign st_b[k+1] = rb;
         assign st_s[k+1] = rs;
         assign st_c[k+1] = rc;
         assign st_v[k+1] = rv;
      end else begin : g_out
         flags_t nf;

         always_comb begin
            nf       = '0;
            nf.cout  = seg_cout;
            nf.overf = seg_cmsb ^ seg_cout;
            nf.zero  = (done == '0);
            nf.neg   = done[WIDTH-1];
         end

         // Result registers load only on real data so bubbles never disturb them.
         always_ff @(posedge clock) begin
            if (reset) begin
               out_valid <= 1'b0;
               sum       <= '0;
               flg       <= '0;
            end else if (advance) begin
               out_valid <= st_v[k];
               if (st_v[k]) begin
                  sum <= done;
                  flg <= nf;
               end
            end
         end
      end
   end

   assign cout  = flg.cout;
   assign overf = flg.overf;
   assign zero  = flg.zero;
   assign neg   = flg.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (WIDTH=32, STAGES=4): hand-computed vector table plus
// scoreboard-checked sequences for streaming, stall, reset and random traffic.
module tb_addsub_pipe;

   localparam int W = 32;
   localparam int S = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout, overf, zero, neg;

   always #5 clock = ~clock;

   addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overf     (overf),
      .zero      (zero),
      .neg       (neg)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] e_sum;
      logic         e_cout, e_ovf, e_zero, e_neg;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c, v, z, n;
   } res_t;

   vec_t vecs [11];
   res_t sbq [$];
   int   out_cyc [$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_in = 0;
   int   n_out = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      res_t         r;
      logic [W:0]   t;
      logic [W-1:0] yb;
      yb  = y ^ {W{s}};
      t   = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, s};
      r.s = t[W-1:0];
      r.c = t[W];
      r.v = (x[W-1] == yb[W-1]) && (t[W-1] != x[W-1]);
      r.z = (t[W-1:0] == '0);
      r.n = t[W-1];
      return r;
   endfunction

   // One clock of traffic: drive at negedge, then observe the handshakes that
   // the coming posedge will perform.
   task automatic cycle(input logic iv, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input logic ordy);
      res_t e;
      @(negedge clock);
      in_valid  = iv;
      a         = xa;
      b         = xb;
      sub       = xs;
      out_ready = ordy;
      #1;
      if (in_valid && in_ready) begin
         sbq.push_back(model(a, b, sub));
         n_in++;
      end
      if (out_valid && out_ready) begin
         n_out++;
         out_cyc.push_back(cyc);
         if (sbq.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
         end else begin
            e = sbq.pop_front();
            check("sb_result", {28'd0, sum, cout, overf, zero, neg}, {28'd0, e});
         end
      end
      cyc++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic got;
      logic [W-1:0] held;
      int   stale;

      vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_sum", {32'd0, sum}, 64'd0);
      check("rst_flags", {60'd0, cout, overf, zero, neg}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Table: one op at a time, exact latency and every output field
      foreach (vecs[i]) begin
         @(negedge clock);
         in_valid  = 1'b1;
         a         = vecs[i].a;
         b         = vecs[i].b;
         sub       = vecs[i].sub;
         out_ready = 1'b1;
         lat = 0;
         got = 1'b0;
         for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clock);
            if (k == 1) in_valid = 1'b0;
            #1;
            if (out_valid) begin
               got = 1'b1;
               lat = k;
            end
         end
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
         check($sformatf("vec%0d_sum", i), {32'd0, sum}, {32'd0, vecs[i].e_sum});
         check($sformatf("vec%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].e_cout});
         check($sformatf("vec%0d_overf", i), {63'd0, overf}, {63'd0, vecs[i].e_ovf});
         check($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].e_zero});
         check($sformatf("vec%0d_neg", i), {63'd0, neg}, {63'd0, vecs[i].e_neg});
      end

      // Back-to-back: 8 ops give 8 results on consecutive cycles, in order
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      out_cyc.delete();
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 32'h1111_1111 * i, 32'hF000_0001 + i, i[0], 1'b1);
      for (int i = 0; i < 8; i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("b2b_count", 64'(out_cyc.size()), 64'd8);
      if (out_cyc.size() == 8)
         check("b2b_consecutive", 64'(out_cyc[7] - out_cyc[0]), 64'd7);

      // Stall: output held, input refused for 3 cycles, nothing lost after release
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h0100_0000 + i, 32'h00FF_FFFF, 1'b0, 1'b1);
      held = '0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         check("stall_out_valid", {63'd0, out_valid}, 64'd1);
         if (i == 0) held = sum;
         else check("stall_sum_hold", {32'd0, sum}, {32'd0, held});
      end
      cycle(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("stall_drain_empty", 64'(sbq.size()), 64'd0);
      check("stall_in_eq_out", 64'(n_out), 64'(n_in));

      // Random traffic with random valid/ready
      for (int i = 0; i < 600; i++)
         cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0) ? '1 : W'($urandom),
               W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 10; i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("rand_drain_empty", 64'(sbq.size()), 64'd0);
      check("rand_in_eq_out", 64'(n_out), 64'(n_in));

      // Reset with 3 ops in flight; in_valid held high during reset is ignored
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'hFFFF_FFF0 + i, 32'h0000_0020, 1'b0, 1'b1);
      @(negedge clock);
      reset    = 1'b1;
      in_valid = 1'b1;
      @(negedge clock);
      #1;
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_sum", {32'd0, sum}, 64'd0);
      check("midrst_flags", {60'd0, cout, overf, zero, neg}, 64'd0);
      @(negedge clock);
      reset    = 1'b0;
      in_valid = 1'b0;
      sbq.delete();
      #1;
      check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         #1;
         if (out_valid) stale++;
      end
      check("midrst_no_stale", 64'(stale), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
